// File: rtl/pipelined_cache_nway_pkg.sv
// Shared types and defaults for the N-way pipelined L1 cache: controller states,
// the held stage-1 request, default geometry and the byte-lane merge helper.
package pipelined_cache_nway_pkg;

    localparam int DEF_S_OFFSET = 5;
    localparam int DEF_S_INDEX  = 3;
    localparam int DEF_NUM_WAYS = 4;
    localparam int DEF_S_TAG    = 32 - DEF_S_OFFSET - DEF_S_INDEX;
    localparam int DEF_S_LINE   = 8 * (2 ** DEF_S_OFFSET);

    typedef enum logic [1:0] {
        RUN,
        WB,
        FILL,
        REPLAY
    } fsm_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        rd;
        logic        wr;
    } req_t;

    typedef logic [DEF_S_LINE-1:0] line_t;
    typedef logic [DEF_S_TAG-1:0]  tag_t;

    // Byte-lane merge of one CPU word; replicated per word this is the bus adapter.
    function automatic logic [31:0] wordMerge(input logic [31:0] oldWord,
                                              input logic [31:0] newWord,
                                              input logic [3:0]  be);
        logic [31:0] merged;
        merged = oldWord;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) merged[8*b +: 8] = newWord[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/pipelined_cache_nway_plru_tree.sv
// Tree pseudo-LRU for one set: returns the updated tree after touching a way
// and the way the current tree points at as victim. Purely combinational.
module plru_tree #(
    parameter  int NUM_WAYS = 4,
    localparam int S_WAY    = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-2:0] bits_i,
    input  logic [S_WAY-1:0]    access_way_i,
    output logic [NUM_WAYS-2:0] bits_o,
    output logic [S_WAY-1:0]    victim_o
);

    // Node (1<<l)-1+p sits at level l; it lies on a way's path when the way's top l bits equal p.
    always_comb begin
        bits_o = bits_i;
        for (int l = 0; l < S_WAY; l++) begin
            for (int p = 0; p < (1 << l); p++) begin
                if ((32'(access_way_i) >> (S_WAY - l)) == 32'(p)) begin
                    bits_o[(1 << l) - 1 + p] = ~access_way_i[S_WAY-1-l];
                end
            end
        end
    end

    always_comb begin
        victim_o = '0;
        for (int l = 0; l < S_WAY; l++) begin
            for (int p = 0; p < (1 << l); p++) begin
                if ((32'(victim_o) >> (S_WAY - l)) == 32'(p)) begin
                    victim_o[S_WAY-1-l] = bits_i[(1 << l) - 1 + p];
                end
            end
        end
    end

endmodule

// File: rtl/pipelined_cache_nway.sv
// N-way set-associative write-back/write-allocate L1 cache with a 2-stage hit path
// (sample, then tag compare/respond) and a RUN/WB/FILL/REPLAY miss controller.
module pipelined_cache_nway
    import pipelined_cache_nway_pkg::*;
#(
    parameter  int S_OFFSET = DEF_S_OFFSET,
    parameter  int S_INDEX  = DEF_S_INDEX,
    parameter  int NUM_WAYS = DEF_NUM_WAYS,
    localparam int S_TAG    = 32 - S_OFFSET - S_INDEX,
    localparam int S_LINE   = 8 * (2 ** S_OFFSET),
    localparam int S_WAY    = $clog2(NUM_WAYS),
    localparam int NUM_SETS = 2 ** S_INDEX,
    localparam int S_WORDS  = 2 ** (S_OFFSET - 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [3:0]        mem_byte_enable,
    input  logic [31:0]       mem_address,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_resp,
    output logic [31:0]       pmem_address,
    input  logic [S_LINE-1:0] pmem_rdata,
    output logic [S_LINE-1:0] pmem_wdata,
    output logic              pmem_read,
    output logic              pmem_write,
    input  logic              pmem_resp
);

    typedef logic [S_WORDS-1:0][31:0] wline_t;

    wline_t               data_q  [NUM_SETS][NUM_WAYS];
    logic [S_TAG-1:0]     tag_q   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]  dirty_q [NUM_SETS];
    logic [NUM_WAYS-2:0]  plru_q  [NUM_SETS];

    fsm_state_e           state_q, state_d;
    req_t                 s1Req_q, s1Req_d;
    logic                 s1Valid_q, s1Valid_d;
    logic [S_WAY-1:0]     victim_q, victim_d;

    logic [S_INDEX-1:0]   idx;
    logic [S_TAG-1:0]     reqTag;
    logic [S_OFFSET-3:0]  wordSel;
    logic [NUM_WAYS-1:0]  hitVec;
    logic                 hit;
    logic [S_WAY-1:0]     hitWay;
    logic [S_WAY-1:0]     invalidWay;
    logic                 anyInvalid;
    logic [S_WAY-1:0]     plruVictim;
    logic [S_WAY-1:0]     victimSel;
    logic [NUM_WAYS-2:0]  plruNext;
    wline_t               hitLine;
    wline_t               mergedLine;
    logic                 sample;
    logic                 hitWrite;
    logic                 fillWrite;
    logic                 unused_bits;

    assign idx     = s1Req_q.addr[S_OFFSET+S_INDEX-1:S_OFFSET];
    assign reqTag  = s1Req_q.addr[31:S_OFFSET+S_INDEX];
    assign wordSel = s1Req_q.addr[S_OFFSET-1:2];

    // Tag compare across ways; a legal cache never holds the same tag twice in a set.
    always_comb begin
        hitVec     = '0;
        hitWay     = '0;
        invalidWay = '0;
        anyInvalid = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hitVec[w] = valid_q[idx][w] && (tag_q[idx][w] == reqTag);
            if (hitVec[w]) hitWay = S_WAY'(w);
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                invalidWay = S_WAY'(w);
                anyInvalid = 1'b1;
            end
        end
    end

    assign hit       = |hitVec;
    assign victimSel = anyInvalid ? invalidWay : plruVictim;
    assign hitLine   = data_q[idx][hitWay];
    assign mem_rdata = hitLine[wordSel];
    assign pmem_wdata = data_q[idx][victim_q];

    always_comb begin
        mergedLine          = hitLine;
        mergedLine[wordSel] = wordMerge(hitLine[wordSel], s1Req_q.wdata, s1Req_q.be);
    end

    plru_tree #(
        .NUM_WAYS (NUM_WAYS)
    ) u_plru (
        .bits_i       (plru_q[idx]),
        .access_way_i (hitWay),
        .bits_o       (plruNext),
        .victim_o     (plruVictim)
    );

    // Miss controller: stage 2 responds in RUN/REPLAY; WB and FILL talk to pmem one at a time.
    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = {reqTag, idx, {S_OFFSET{1'b0}}};
        fillWrite    = 1'b0;
        case (state_q)
            RUN: begin
                if (s1Valid_q) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                    end else begin
                        victim_d = victimSel;
                        state_d  = (valid_q[idx][victimSel] && dirty_q[idx][victimSel]) ? WB : FILL;
                    end
                end
            end
            WB: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[idx][victim_q], idx, {S_OFFSET{1'b0}}};
                if (pmem_resp) state_d = FILL;
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    fillWrite = 1'b1;
                    state_d   = REPLAY;
                end
            end
            REPLAY: begin
                mem_resp = s1Valid_q && hit;
                state_d  = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign hitWrite = mem_resp && s1Req_q.wr;
    assign sample   = (mem_read || mem_write) && (state_q == RUN) && !(s1Valid_q && !hit);

    always_comb begin
        s1Req_d   = s1Req_q;
        s1Valid_d = s1Valid_q;
        if (sample) begin
            s1Valid_d     = 1'b1;
            s1Req_d.addr  = mem_address;
            s1Req_d.wdata = mem_wdata;
            s1Req_d.be    = mem_byte_enable;
            s1Req_d.wr    = mem_write;
            s1Req_d.rd    = mem_read && !mem_write;
        end else if (mem_resp) begin
            s1Valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            s1Req_q   <= '0;
            s1Valid_q <= 1'b0;
            victim_q  <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            s1Req_q   <= s1Req_d;
            s1Valid_q <= s1Valid_d;
            victim_q  <= victim_d;
            if (mem_resp) plru_q[idx] <= plruNext;
            if (fillWrite) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
            end
            if (hitWrite) dirty_q[idx][hitWay] <= 1'b1;
        end
    end

    // Line storage carries no reset; valid bits guard against stale contents.
    always_ff @(posedge clk) begin
        if (fillWrite) begin
            data_q[idx][victim_q] <= pmem_rdata;
            tag_q[idx][victim_q]  <= reqTag;
        end
        if (hitWrite) data_q[idx][hitWay] <= mergedLine;
    end

    assign unused_bits = ^{s1Req_q.addr[1:0], s1Req_q.rd};

    a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst) !(mem_read && mem_write));

endmodule
